// File: rtl/onehot_pkg.sv
// Shared definitions for the one-hot encoder: buffer state encoding and
// error-counter limits.
package onehot_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    localparam int                   ERR_CNT_W   = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'hFF;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == ERR_CNT_MAX) ? v : v + ERR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/onehot_if.sv
// Handshake bundle between a one-hot word producer/consumer (master) and the
// encoder (slave).
interface onehot_if
    import onehot_pkg::*;
#(
    parameter int WIDTH = 4
) ();
    localparam int IDX_W = $clog2(WIDTH);

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_code;
    logic                 out_valid;
    logic                 out_ready;
    logic [IDX_W-1:0]     out_idx;
    logic                 out_multi;
    logic                 out_zero;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output in_valid, in_code, out_ready,
        input  in_ready, out_valid, out_idx, out_multi, out_zero, err_count
    );

    modport slave (
        input  in_valid, in_code, out_ready,
        output in_ready, out_valid, out_idx, out_multi, out_zero, err_count
    );
endinterface

// File: rtl/onehot_prio_enc.sv
// Combinational LSB-priority encoder with multi-bit and all-zero flags.
module onehot_prio_enc #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]         code_i,
    output logic [$clog2(WIDTH)-1:0] idx_o,
    output logic                     multi_o,
    output logic                     zero_o
);
    localparam int IDX_W = $clog2(WIDTH);

    // Scan from the top down so the lowest set bit is the last assignment.
    always_comb begin
        idx_o = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (code_i[i]) idx_o = i[IDX_W-1:0];
        end
    end

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_o = |(code_i & (code_i - WIDTH'(1)));
    assign zero_o  = ~|code_i;
endmodule

// File: rtl/onehot_encoder.sv
// One-hot to binary encoder with a 2-entry FIFO output buffer and a
// saturating count of non-one-hot words.
module onehot_encoder
    import onehot_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    onehot_if.slave  bus
);
    localparam int IDX_W = $clog2(WIDTH);

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             multi;
        logic             zero;
    } entry_t;

    logic [1:0]           state_q, state_d;
    entry_t               head_q, head_d;
    entry_t               tail_q, tail_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;
    entry_t               enc;
    logic                 accept;
    logic                 pop;

    onehot_prio_enc #(.WIDTH(WIDTH)) u_enc (
        .code_i  (bus.in_code),
        .idx_o   (enc.idx),
        .multi_o (enc.multi),
        .zero_o  (enc.zero)
    );

    assign bus.in_ready  = (state_q != ST_TWO);
    assign bus.out_valid = (state_q != ST_EMPTY);
    assign bus.out_idx   = head_q.idx;
    assign bus.out_multi = head_q.multi;
    assign bus.out_zero  = head_q.zero;
    assign bus.err_count = err_q;

    assign accept = bus.in_valid && (state_q != ST_TWO);
    assign pop    = bus.out_ready && (state_q != ST_EMPTY);

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        err_d   = err_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    head_d  = enc;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                // Simultaneous accept and pop replaces the head in place.
                if (accept && pop) begin
                    head_d = enc;
                end else if (accept) begin
                    tail_d  = enc;
                    state_d = ST_TWO;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (pop) begin
                    head_d  = tail_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (accept && (enc.multi || enc.zero)) err_d = sat_inc(err_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_onehot_encoder.sv
// Scoreboard bench for onehot_encoder: expected entries are queued on accept
// and compared when the DUT pops them.
module tb_onehot_encoder;
    localparam int WIDTH = 4;
    localparam int IDX_W = 2;
    localparam int EW    = IDX_W + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   pops = 0;
    int   exp_err = 0;
    logic [EW-1:0] sb_q[$];

    onehot_if #(.WIDTH(WIDTH)) bus ();

    onehot_encoder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [EW-1:0] model(input logic [WIDTH-1:0] code);
        logic [IDX_W-1:0] idx;
        logic found;
        idx = '0;
        found = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (code[i] && !found) begin
                idx = IDX_W'(i);
                found = 1'b1;
            end
        end
        return {idx, ($countones(code) > 1), (code == '0)};
    endfunction

    // Pop side of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            logic [EW-1:0] e;
            total++;
            pops++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL pop_unexpected: got idx=%0d multi=%0b zero=%0b, expected no output",
                         bus.out_idx, bus.out_multi, bus.out_zero);
            end else begin
                e = sb_q.pop_front();
                if ({bus.out_idx, bus.out_multi, bus.out_zero} !== e) begin
                    bad++;
                    $display("FAIL pop_data: got {idx,multi,zero}=%b expected %b",
                             {bus.out_idx, bus.out_multi, bus.out_zero}, e);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [WIDTH-1:0] code);
        bit done = 0;
        bus.in_valid = 1'b1;
        bus.in_code  = code;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb_q.push_back(model(code));
                if ($countones(code) != 1 && exp_err < 255) exp_err++;
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL send_timeout: code=%b never accepted, expected acceptance", code);
        end
    endtask

    task automatic drain();
        bit done = 0;
        for (int k = 0; k < 60 && !done; k++) begin
            if (sb_q.size() == 0 && !bus.out_valid) done = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL drain_timeout: queue=%0d out_valid=%0b, expected 0 and 0",
                     sb_q.size(), bus.out_valid);
        end
    endtask

    task automatic check_err(input string name);
        total++;
        if (bus.err_count !== exp_err[7:0]) begin
            bad++;
            $display("FAIL %s: err_count=%0d expected %0d", name, bus.err_count, exp_err);
        end
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.in_code   = '0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({bus.in_ready, bus.out_valid, bus.out_idx, bus.out_multi, bus.out_zero} !== 6'b100000) begin
            bad++;
            $display("FAIL reset_outputs: {rdy,vld,idx,multi,zero}=%b expected 100000",
                     {bus.in_ready, bus.out_valid, bus.out_idx, bus.out_multi, bus.out_zero});
        end
        check_err("reset_err");
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_stream();
        int start;
        bus.out_ready = 1'b1;
        start = cyc;
        send(4'b0001);
        send(4'b0010);
        send(4'b0100);
        send(4'b1000);
        total++;
        if (cyc - start !== 4) begin
            bad++;
            $display("FAIL stream_throughput: took %0d cycles expected 4", cyc - start);
        end
        drain();
        check_err("stream_err");
    endtask

    task automatic test_backpressure();
        int p0;
        bus.out_ready = 1'b0;
        p0 = pops;
        send(4'b0010);
        send(4'b1000);
        total++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL bp_full: in_ready=%0b out_valid=%0b expected 0 and 1",
                     bus.in_ready, bus.out_valid);
        end
        bus.in_valid = 1'b1;
        bus.in_code  = 4'b0001;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (bus.in_ready !== 1'b0 || bus.out_idx !== 2'd1) begin
            bad++;
            $display("FAIL bp_hold: in_ready=%0b out_idx=%0d expected 0 and 1",
                     bus.in_ready, bus.out_idx);
        end
        bus.out_ready = 1'b1;
        send(4'b0001);
        drain();
        total++;
        if (pops - p0 !== 3) begin
            bad++;
            $display("FAIL bp_count: popped %0d expected 3", pops - p0);
        end
    endtask

    task automatic test_invalid();
        bus.out_ready = 1'b1;
        send(4'b0110);
        send(4'b0000);
        drain();
        check_err("invalid_err");
        total++;
        if (exp_err !== 2) begin
            bad++;
            $display("FAIL invalid_model: model err=%0d expected 2", exp_err);
        end
    endtask

    task automatic test_saturation();
        bus.out_ready = 1'b1;
        for (int n = 0; n < 300; n++) send(4'b1111);
        drain();
        check_err("sat_err");
        total++;
        if (bus.err_count !== 8'd255) begin
            bad++;
            $display("FAIL sat_value: err_count=%0d expected 255", bus.err_count);
        end
    endtask

    task automatic test_simul();
        bus.out_ready = 1'b0;
        send(4'b0100);
        total++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1 || bus.out_idx !== 2'd2) begin
            bad++;
            $display("FAIL simul_one: vld=%0b rdy=%0b idx=%0d expected 1 1 2",
                     bus.out_valid, bus.in_ready, bus.out_idx);
        end
        bus.out_ready = 1'b1;
        send(4'b0001);
        total++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1 || bus.out_idx !== 2'd0) begin
            bad++;
            $display("FAIL simul_replace: vld=%0b rdy=%0b idx=%0d expected 1 1 0",
                     bus.out_valid, bus.in_ready, bus.out_idx);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        send(4'b0011);
        send(4'b0010);
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL mid_full: in_ready=%0b expected 0", bus.in_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        sb_q.delete();
        exp_err = 0;
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_idx !== 2'd0) begin
            bad++;
            $display("FAIL mid_reset: vld=%0b rdy=%0b idx=%0d expected 0 1 0",
                     bus.out_valid, bus.in_ready, bus.out_idx);
        end
        check_err("mid_reset_err");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(4'b1000);
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_idx !== 2'd3) begin
            bad++;
            $display("FAIL mid_after: vld=%0b idx=%0d expected 1 3", bus.out_valid, bus.out_idx);
        end
        bus.out_ready = 1'b1;
        drain();
        check_err("mid_after_err");
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_invalid();
        test_saturation();
        test_simul();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
